// File: rtl/dmem_pipe.sv
// dmem_pipe: single-port data memory with valid/ready requests and an in-order response pipeline.
// Define DMEM_PARITY_EN for per-byte even parity storage and error reporting.
module dmem_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8192,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
`ifdef DMEM_PARITY_EN
  input  logic                  inj_perr,
  output logic                  rsp_perr,
`endif
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic                  rsp_we,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

  logic              w_stall;
  logic              w_acc;
  logic              w_inr;
  logic              w_wr;
  logic              w_rd;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_we;
  logic [RD_LAT-1:0] r_err;
  logic [DATA_W-1:0] r_data [RD_LAT];

  assign w_stall = r_vld[RD_LAT-1] & ~rsp_rdy;
  assign req_rdy = ~w_stall;
  assign w_acc   = req_vld & req_rdy;
  assign w_inr   = {1'b0, req_addr} < LIM;
  assign w_idx   = req_addr[IDX_W-1:0];
  assign w_wr    = w_acc & req_we & w_inr;
  assign w_rd    = w_acc & ~req_we & w_inr;
  assign w_rdata = w_rd ? r_mem[w_idx] : '0;

`ifdef DMEM_PARITY_EN
  logic [BE_W-1:0]   r_par [DEPTH];
  logic [BE_W-1:0]   w_wpar;
  logic [BE_W-1:0]   w_rpar;
  logic              w_perr;
  logic [RD_LAT-1:0] r_perr;

  always_comb begin
    w_wpar = '0;
    w_rpar = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_wpar[i] = (^req_wdata[8*i +: 8]) ^ inj_perr;
      w_rpar[i] = ^w_rdata[8*i +: 8];
    end
  end

  assign w_perr = w_rd & (|(w_rpar ^ r_par[w_idx]));
`endif

  // Array has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
          r_par[w_idx][i] <= w_wpar[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_we  <= '0;
      r_err <= '0;
      for (int k = 0; k < RD_LAT; k++) r_data[k] <= '0;
`ifdef DMEM_PARITY_EN
      r_perr <= '0;
`endif
    end else if (!w_stall) begin
      r_vld[0]  <= w_acc;
      r_we[0]   <= w_acc & req_we;
      r_err[0]  <= w_acc & ~w_inr;
      r_data[0] <= w_rdata;
`ifdef DMEM_PARITY_EN
      r_perr[0] <= w_perr;
`endif
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_we[k]   <= r_we[k-1];
        r_err[k]  <= r_err[k-1];
        r_data[k] <= r_data[k-1];
`ifdef DMEM_PARITY_EN
        r_perr[k] <= r_perr[k-1];
`endif
      end
    end
  end

  assign rsp_vld   = r_vld[RD_LAT-1];
  assign rsp_we    = r_we[RD_LAT-1];
  assign rsp_err   = r_err[RD_LAT-1];
  assign rsp_rdata = r_data[RD_LAT-1];
`ifdef DMEM_PARITY_EN
  assign rsp_perr  = r_perr[RD_LAT-1];
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed self-checking bench for dmem_pipe.
// Runs with RD_LAT=3; parity scenario only when DMEM_PARITY_EN is defined.
module tb_dmem_pipe;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        rsp_rdy = 1'b1;
  logic        req_rdy;
  logic        rsp_vld;
  logic        rsp_we;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic        w_perr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic        err;
    logic        perr;
    logic [15:0] data;
  } rsp_t;

  rsp_t rq[$];

  always #5 clk = ~clk;

`ifdef DMEM_PARITY_EN
  logic inj_perr = 1'b0;
  logic rsp_perr;
  assign w_perr = rsp_perr;
`else
  assign w_perr = 1'b0;
`endif

  dmem_pipe #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH (8192),
    .RD_LAT(RD_LAT)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
`ifdef DMEM_PARITY_EN
    .inj_perr (inj_perr),
    .rsp_perr (rsp_perr),
`endif
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_we   (rsp_we),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  // Records every response that will be consumed at the coming posedge.
  always @(negedge clk) begin
    #2;
    if (rst_n && rsp_vld && rsp_rdy)
      rq.push_back({rsp_we, rsp_err, w_perr, rsp_rdata});
  end

  // Called just after a negedge; one accepted request (rsp_rdy held high).
  task automatic send(input logic we, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_vld   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_vld   = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++; $display("FAIL reset_vld: got %b expected 0", rsp_vld);
    end
    checks++;
    if (rsp_we !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_we_err: got %b%b expected 00", rsp_we, rsp_err);
    end
    checks++;
    if (rsp_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0000", rsp_rdata);
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy: got %b expected 1", req_rdy);
    end
    checks++;
    if (w_perr !== 1'b0) begin
      errors++; $display("FAIL reset_perr: got %b expected 0", w_perr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'hBEEF; req_be = 2'b11;
    req_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b0; req_wdata = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++; $display("FAIL wr_early_vld: got %b expected 0", rsp_vld);
    end
    repeat (RD_LAT - 2) @(negedge clk);
    checks++;
    if ({rsp_vld, rsp_we, rsp_err, rsp_rdata} !== {3'b110, 16'h0000}) begin
      errors++;
      $display("FAIL wr_rsp: got vld=%b we=%b err=%b data=%h expected 1 1 0 0000",
               rsp_vld, rsp_we, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({rsp_vld, rsp_we, rsp_err, rsp_rdata} !== {3'b100, 16'hBEEF}) begin
      errors++;
      $display("FAIL rd_rsp: got vld=%b we=%b err=%b data=%h expected 1 0 0 beef",
               rsp_vld, rsp_we, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++; $display("FAIL rd_dup: got vld=%b expected 0", rsp_vld);
    end
  endtask

  task automatic test_byte_en;
    rq.delete();
    send(1'b1, 16'd9, 16'h1234, 2'b11);
    send(1'b1, 16'd9, 16'hAB00, 2'b10);
    send(1'b0, 16'd9, 16'h0000, 2'b00);
    for (int k = 0; k < 40 && rq.size() < 3; k++) begin
      @(negedge clk); #3;
    end
    checks++;
    if (rq.size() !== 3) begin
      errors++; $display("FAIL be_count: got %0d expected 3", rq.size());
    end else begin
      checks++;
      if (rq[0].we !== 1'b1 || rq[0].data !== 16'h0000) begin
        errors++; $display("FAIL be_wr_rsp: got we=%b data=%h expected 1 0000",
                           rq[0].we, rq[0].data);
      end
      checks++;
      if (rq[2].we !== 1'b0 || rq[2].data !== 16'hAB34) begin
        errors++; $display("FAIL be_merge: got we=%b data=%h expected 0 ab34",
                           rq[2].we, rq[2].data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int          issued;
    int          cyc;
    int          stalls;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [15:0] exp;
    for (int i = 0; i < 8; i++)
      send(1'b1, 16'(i), 16'h1000 + 16'(i) * 16'h0111, 2'b11);
    for (int k = 0; k < 40 && rq.size() < 11; k++) begin
      @(negedge clk); #3;
    end
    @(negedge clk);
    rq.delete();
    issued = 0; cyc = 0; stalls = 0; prev_stall = 1'b0; prev_data = '0;
    while ((issued < 8 || rq.size() < 8) && cyc < 60) begin
      rsp_rdy  = !(cyc >= 4 && cyc <= 6);
      req_vld  = (issued < 8);
      req_we   = 1'b0;
      req_addr = 16'(issued);
      req_be   = 2'b00;
      #1;
      checks++;
      if (req_rdy !== !(rsp_vld && !rsp_rdy)) begin
        errors++; $display("FAIL b2b_rdy cyc%0d: got %b with vld=%b rsp_rdy=%b",
                           cyc, req_rdy, rsp_vld, rsp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== prev_data) begin
          errors++; $display("FAIL b2b_hold cyc%0d: got vld=%b data=%h expected 1 %h",
                             cyc, rsp_vld, rsp_rdata, prev_data);
        end
      end
      prev_stall = rsp_vld && !rsp_rdy;
      prev_data  = rsp_rdata;
      if (prev_stall) stalls++;
      if (req_vld && req_rdy) issued++;
      #2;
      @(negedge clk);
      cyc++;
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    checks++;
    if (stalls !== 3) begin
      errors++; $display("FAIL b2b_stalls: got %0d expected 3", stalls);
    end
    checks++;
    if (rq.size() !== 8) begin
      errors++; $display("FAIL b2b_count: got %0d expected 8", rq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp = 16'h1000 + 16'(i) * 16'h0111;
        checks++;
        if (rq[i].data !== exp || rq[i].we !== 1'b0 || rq[i].err !== 1'b0) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, rq[i].data, exp);
        end
      end
    end
  endtask

  task automatic test_range;
    rq.delete();
    send(1'b0, 16'd8192, 16'h0000, 2'b00);
    send(1'b1, 16'd8192, 16'hFFFF, 2'b11);
    send(1'b0, 16'd0, 16'h0000, 2'b00);
    for (int k = 0; k < 40 && rq.size() < 3; k++) begin
      @(negedge clk); #3;
    end
    checks++;
    if (rq.size() !== 3) begin
      errors++; $display("FAIL rng_count: got %0d expected 3", rq.size());
    end else begin
      checks++;
      if (rq[0].err !== 1'b1 || rq[0].data !== 16'h0000) begin
        errors++; $display("FAIL rng_rd: got err=%b data=%h expected 1 0000",
                           rq[0].err, rq[0].data);
      end
      checks++;
      if (rq[1].err !== 1'b1 || rq[1].we !== 1'b1) begin
        errors++; $display("FAIL rng_wr: got err=%b we=%b expected 1 1",
                           rq[1].err, rq[1].we);
      end
      checks++;
      if (rq[2].err !== 1'b0 || rq[2].data !== 16'h1000) begin
        errors++; $display("FAIL rng_alias: got err=%b data=%h expected 0 1000",
                           rq[2].err, rq[2].data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    rq.delete();
    send(1'b1, 16'd20, 16'h7777, 2'b11);
    req_we = 1'b0; req_addr = 16'd1; req_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 16'd2;
    @(posedge clk);
    @(negedge clk);
    req_addr = 16'd3;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    checks++;
    if (rsp_vld !== 1'b1) begin
      errors++; $display("FAIL mid_inflight: got vld=%b expected 1", rsp_vld);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
      errors++; $display("FAIL mid_clear: got vld=%b rdy=%b expected 0 1", rsp_vld, req_rdy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rq.delete();
    repeat (8) begin
      @(negedge clk); #3;
    end
    checks++;
    if (rq.size() !== 0 || rsp_vld !== 1'b0) begin
      errors++; $display("FAIL mid_ghost: got %0d responses vld=%b expected 0 0",
                         rq.size(), rsp_vld);
    end
    @(negedge clk);
    send(1'b0, 16'd20, 16'h0000, 2'b00);
    for (int k = 0; k < 40 && rq.size() < 1; k++) begin
      @(negedge clk); #3;
    end
    checks++;
    if (rq.size() !== 1 || rq[0].data !== 16'h7777) begin
      errors++; $display("FAIL mid_persist: got n=%0d data=%h expected 1 7777",
                         rq.size(), (rq.size() > 0) ? rq[0].data : 16'h0000);
    end
    @(negedge clk);
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity;
    rq.delete();
    inj_perr = 1'b1;
    send(1'b1, 16'd30, 16'h00FF, 2'b11);
    inj_perr = 1'b0;
    send(1'b0, 16'd30, 16'h0000, 2'b00);
    send(1'b1, 16'd30, 16'h00FF, 2'b11);
    send(1'b0, 16'd30, 16'h0000, 2'b00);
    for (int k = 0; k < 40 && rq.size() < 4; k++) begin
      @(negedge clk); #3;
    end
    checks++;
    if (rq.size() !== 4) begin
      errors++; $display("FAIL par_count: got %0d expected 4", rq.size());
    end else begin
      checks++;
      if (rq[0].perr !== 1'b0) begin
        errors++; $display("FAIL par_wr: got perr=%b expected 0", rq[0].perr);
      end
      checks++;
      if (rq[1].perr !== 1'b1 || rq[1].data !== 16'h00FF) begin
        errors++; $display("FAIL par_inj: got perr=%b data=%h expected 1 00ff",
                           rq[1].perr, rq[1].data);
      end
      checks++;
      if (rq[3].perr !== 1'b0 || rq[3].data !== 16'h00FF) begin
        errors++; $display("FAIL par_clean: got perr=%b data=%h expected 0 00ff",
                           rq[3].perr, rq[3].data);
      end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_byte_en;
    test_back_to_back;
    test_range;
    test_reset_mid;
`ifdef DMEM_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
